// File: rtl/dm_store_queue.sv
// rtl/dm_store_queue.sv - in-order word store queue sharing the data memory port with loads
//
// Buffers up to DEPTH word stores from the MEM stage. The queue drains them in order into a
// single-port, word-granular data memory whenever no load needs the port. It also flags loads
// whose word address hits a queued store, so the pipeline can stall until that store has drained.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; clears the queue immediately
//   st_valid     store request; accepted when st_ready is high
//   st_addr      store byte address (bits [1:0] ignored)
//   st_data      full store word
//   st_pc        PC of the store, carried to dm_pc for write logging
//   st_ready     queue has a free entry
//   ld_valid     a load wants the memory port this cycle
//   ld_addr      load byte address
//   ld_conflict  load word address matches a queued store
//   dm_we        memory write enable (a store drains this cycle)
//   dm_addr      memory address: head store while draining, otherwise ld_addr
//   dm_wd        memory write data (head entry)
//   dm_pc        PC of the head entry
//   count        number of valid entries (registered)
//   empty        count == 0
module dm_store_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [31:0]   st_pc,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_conflict,
    output logic          dm_we,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_wd,
    output logic [31:0]   dm_pc,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]    q_addr [DEPTH];
    logic [31:0]    q_data [DEPTH];
    logic [31:0]    q_pc   [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] match_vec;
    logic [PW-1:0]    offset;
    logic             push;
    logic             drain;

    // Byte-offset bits of a store address carry no information for a word memory.
    logic unused_st_lsb;
    assign unused_st_lsb = ^st_addr[1:0];

    // An entry is live when its distance from head (mod DEPTH) is below count, so stale
    // slots left behind by earlier pops can never produce a false conflict.
    always_comb begin
        valid_vec = '0;
        match_vec = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PW'(i) - head;
            valid_vec[i] = ({{(CW-PW){1'b0}}, offset} < count);
            match_vec[i] = valid_vec[i] && (q_addr[i] == ld_addr[31:2]);
        end
    end

    assign empty       = (count == '0);
    assign st_ready    = (count != CW'(DEPTH));
    assign ld_conflict = ld_valid && (|match_vec);
    assign push        = st_valid && st_ready;

    // A conflicting load gives the port to the queue; a non-conflicting load takes it.
    // Either way the oldest store eventually drains, so a stalled load always makes progress.
    assign drain   = !empty && (!ld_valid || ld_conflict);
    assign dm_we   = drain;
    assign dm_addr = drain ? {q_addr[head], 2'b00} : ld_addr;
    assign dm_wd   = q_data[head];
    assign dm_pc   = q_pc[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                q_addr[tail] <= st_addr[31:2];
                q_data[tail] <= st_data;
                q_pc[tail]   <= st_pc;
                tail         <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_queue.sv
// tb/tb_dm_store_queue.sv - randomized self-checking bench for dm_store_queue
module tb_dm_store_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          st_valid = 1'b0;
    logic [31:0]   st_addr = '0;
    logic [31:0]   st_data = '0;
    logic [31:0]   st_pc = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_addr = 32'h0000_0ABC;
    logic          ld_conflict;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wd;
    logic [31:0]   dm_pc;
    logic [CW-1:0] count;
    logic          empty;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];

    dm_store_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic bit m_conflict();
        if (!ld_valid) return 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_drain();
        return (mq.size() != 0) && (!ld_valid || m_conflict());
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drain() ? {mq[0].addr[31:2], 2'b00} : ld_addr;
    endfunction

    // Advance one clock: the model commits the pop/push decided by pre-edge state and inputs.
    task automatic tick();
        bit   d;
        bit   p;
        ent_t e;
        d = m_drain();
        p = st_valid && (mq.size() < DEPTH);
        e = '{addr: st_addr, data: st_data, pc: st_pc};
        @(posedge clk);
        #1;
        if (d) void'(mq.pop_front());
        if (p) mq.push_back(e);
    endtask

    task automatic test_reset();
        #3;
        n_vec += 6;
        if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
        if (dm_we !== 1'b0) begin n_err++; $display("FAIL reset_dm_we: got %b expected 0", dm_we); end
        if (dm_addr !== 32'h0000_0ABC) begin n_err++; $display("FAIL reset_dm_addr: got %h expected 00000abc", dm_addr); end
        if (dm_wd !== 32'h0) begin n_err++; $display("FAIL reset_dm_wd: got %h expected 00000000", dm_wd); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Park two stores behind a non-matching load, then reset between clock edges.
        ld_valid = 1'b1; ld_addr = 32'h0000_7000;
        st_valid = 1'b1; st_addr = 32'h8; st_data = 32'h1111_1111; st_pc = 32'h100;
        tick();
        st_addr = 32'hC; st_data = 32'h2222_2222; st_pc = 32'h104;
        tick();
        st_valid = 1'b0;
        n_vec++;
        if (count !== 3'd2) begin n_err++; $display("FAIL reset_prefill_count: got %0d expected 2", count); end
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        n_vec += 3;
        if (count !== '0) begin n_err++; $display("FAIL async_reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL async_reset_empty: got %b expected 1", empty); end
        if (dm_we !== 1'b0) begin n_err++; $display("FAIL async_reset_dm_we: got %b expected 0", dm_we); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        ld_valid = 1'b0;
    endtask

    task automatic test_single_store();
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h1234_5678; st_pc = 32'h0000_2000;
        tick();
        st_valid = 1'b0;
        #1;
        n_vec += 4;
        if (dm_we !== 1'b1) begin n_err++; $display("FAIL single_dm_we: got %b expected 1", dm_we); end
        if (dm_addr !== 32'h10) begin n_err++; $display("FAIL single_dm_addr: got %h expected 00000010", dm_addr); end
        if (dm_wd !== 32'h1234_5678) begin n_err++; $display("FAIL single_dm_wd: got %h expected 12345678", dm_wd); end
        if (dm_pc !== 32'h0000_2000) begin n_err++; $display("FAIL single_dm_pc: got %h expected 00002000", dm_pc); end
        tick();
        n_vec++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fill_under_load();
        ld_valid = 1'b1; ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'(i * 4); st_data = 32'hD000_0000 + 32'(i); st_pc = 32'h300 + 32'(i * 4);
            tick();
        end
        st_valid = 1'b0;
        #1;
        n_vec += 5;
        if (count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d expected 4", count); end
        if (st_ready !== 1'b0) begin n_err++; $display("FAIL fill_st_ready: got %b expected 0", st_ready); end
        if (dm_we !== 1'b0) begin n_err++; $display("FAIL fill_dm_we: got %b expected 0", dm_we); end
        if (dm_addr !== 32'h100) begin n_err++; $display("FAIL fill_dm_addr: got %h expected 00000100", dm_addr); end
        if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL fill_conflict: got %b expected 0", ld_conflict); end
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec += 3;
            if (dm_we !== 1'b1) begin n_err++; $display("FAIL fill_drain_we[%0d]: got %b expected 1", i, dm_we); end
            if (dm_addr !== 32'(i * 4)) begin n_err++; $display("FAIL fill_drain_addr[%0d]: got %h expected %h", i, dm_addr, 32'(i * 4)); end
            if (dm_wd !== 32'hD000_0000 + 32'(i)) begin n_err++; $display("FAIL fill_drain_wd[%0d]: got %h expected %h", i, dm_wd, 32'hD000_0000 + 32'(i)); end
            tick();
        end
        n_vec++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty: got %b expected 1", empty); end
    endtask

    task automatic test_conflict();
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hAAAA_AAAA; st_pc = 32'h400;
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h22;
        #1;
        n_vec += 4;
        if (ld_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_hit: got %b expected 1", ld_conflict); end
        if (dm_we !== 1'b1) begin n_err++; $display("FAIL conflict_dm_we: got %b expected 1", dm_we); end
        if (dm_addr !== 32'h20) begin n_err++; $display("FAIL conflict_dm_addr: got %h expected 00000020", dm_addr); end
        if (dm_wd !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL conflict_dm_wd: got %h expected aaaaaaaa", dm_wd); end
        tick();
        n_vec += 3;
        if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL conflict_clear: got %b expected 0", ld_conflict); end
        if (dm_we !== 1'b0) begin n_err++; $display("FAIL conflict_after_we: got %b expected 0", dm_we); end
        if (dm_addr !== 32'h22) begin n_err++; $display("FAIL conflict_after_addr: got %h expected 00000022", dm_addr); end
        ld_valid = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [31:0] order [3];
        order[0] = 32'h50; order[1] = 32'h60; order[2] = 32'h40;
        ld_valid = 1'b1; ld_addr = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            st_valid = 1'b1; st_addr = order[i]; st_data = 32'hBEEF_0000 + 32'(i); st_pc = 32'h500 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hBEEF_0002; st_pc = 32'h502;
        tick();
        st_valid = 1'b0;
        n_vec++;
        if (count !== 3'd2) begin n_err++; $display("FAIL pushpop_count: got %0d expected 2", count); end
        for (int i = 1; i < 3; i++) begin
            #1;
            n_vec += 2;
            if (dm_addr !== order[i]) begin n_err++; $display("FAIL pushpop_order[%0d]: got %h expected %h", i, dm_addr, order[i]); end
            if (dm_wd !== 32'hBEEF_0000 + 32'(i)) begin n_err++; $display("FAIL pushpop_wd[%0d]: got %h expected %h", i, dm_wd, 32'hBEEF_0000 + 32'(i)); end
            tick();
        end
        n_vec++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL pushpop_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        ent_t exp[$];
        int   k = 0;
        ld_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                st_valid = 1'b1;
                st_addr  = 32'h200 + 32'(i * 4) + 32'($urandom_range(0, 3));
                st_data  = $urandom;
                st_pc    = $urandom;
                exp.push_back('{addr: st_addr, data: st_data, pc: st_pc});
            end else begin
                st_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                n_vec += 4;
                if (dm_we !== 1'b1) begin n_err++; $display("FAIL wrap_we[%0d]: got %b expected 1", k, dm_we); end
                if (dm_addr !== {exp[k].addr[31:2], 2'b00}) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, dm_addr, {exp[k].addr[31:2], 2'b00}); end
                if (dm_wd !== exp[k].data) begin n_err++; $display("FAIL wrap_wd[%0d]: got %h expected %h", k, dm_wd, exp[k].data); end
                if (dm_pc !== exp[k].pc) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, dm_pc, exp[k].pc); end
                k++;
            end
            tick();
        end
        n_vec += 2;
        if (count !== '0) begin n_err++; $display("FAIL wrap_count: got %0d expected 0", count); end
        if (dm_we !== 1'b0) begin n_err++; $display("FAIL wrap_idle_we: got %b expected 0", dm_we); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            st_valid = ($urandom_range(0, 3) != 0);
            st_addr  = 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            st_data  = $urandom;
            st_pc    = $urandom;
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_addr  = 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
            #1;
            n_vec += 6;
            if (st_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_st_ready[%0d]: got %b expected %b", c, st_ready, mq.size() < DEPTH); end
            if (ld_conflict !== m_conflict()) begin n_err++; $display("FAIL rnd_conflict[%0d]: got %b expected %b", c, ld_conflict, m_conflict()); end
            if (dm_we !== m_drain()) begin n_err++; $display("FAIL rnd_dm_we[%0d]: got %b expected %b", c, dm_we, m_drain()); end
            if (dm_addr !== m_addr()) begin n_err++; $display("FAIL rnd_dm_addr[%0d]: got %h expected %h", c, dm_addr, m_addr()); end
            if (count !== CW'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
            if (empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b expected %b", c, empty, mq.size() == 0); end
            if (m_drain()) begin
                n_vec += 2;
                if (dm_wd !== mq[0].data) begin n_err++; $display("FAIL rnd_dm_wd[%0d]: got %h expected %h", c, dm_wd, mq[0].data); end
                if (dm_pc !== mq[0].pc) begin n_err++; $display("FAIL rnd_dm_pc[%0d]: got %h expected %h", c, dm_pc, mq[0].pc); end
            end
            tick();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        for (int c = 0; c < 2 * DEPTH; c++) tick();
        n_vec++;
        if (empty !== 1'b1) begin n_err++; $display("FAIL rnd_final_empty: got %b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill_under_load();
        test_conflict();
        test_push_pop();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_store_queue.md
# dm_store_queue

Four-entry FIFO store queue between the MEM-stage store path and the data memory's single shared address/write port. It accepts word stores, drains them in order into data memory whenever the port is not needed by a load, and flags any load whose word address matches a pending store so the pipeline stalls until that store has drained. It writes to the same word-granular, single-port memory: one address drives both the combinational read and the synchronous write.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- CW, $clog2(DEPTH+1), width of `count`
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears queue immediately
- st_valid  in  1  store request from MEM stage
- st_addr  in  32  store byte address; bits [1:0] ignored
- st_data  in  32  full store word (byte merging done upstream)
- st_pc  in  32  PC of the store, carried for write logging
- st_ready  out  1  queue can accept a store this cycle
- ld_valid  in  1  load wants the memory port this cycle
- ld_addr  in  32  load byte address
- ld_conflict  out  1  load word address matches a queued store; stall
- dm_we  out  1  memory write enable
- dm_addr  out  32  memory address (load or drain)
- dm_wd  out  32  memory write data
- dm_pc  out  32  PC of the draining store
- count  out  CW  valid entries
- empty  out  1  count == 0

## Operation
- Storage: DEPTH entries of {addr[31:2], data, pc}; head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH; count is separate.
- Push: st_valid && st_ready. Write at tail, tail+1. st_ready = (count != DEPTH); no pass-through when full.
- Match (combinational): ld_conflict = ld_valid && any valid entry with entry.addr == ld_addr[31:2]. Compare valid entries only; stale slots never match.
- Drain: drain = !empty && (!ld_valid || ld_conflict). A conflicting load yields the port to the queue; otherwise the load wins, and deadlock is impossible.
- Port mux: dm_we = drain; dm_addr = drain ? {head.addr,2'b00} : ld_addr; dm_wd = head.data; dm_pc = head.pc. When !drain, dm_wd/dm_pc are don't-care, but must not be X after reset.
- Pop: drain asserted at a rising edge → head+1.
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- A store pushed in the same cycle as a load is not compared against that load. The pipeline never issues both in one cycle; if it does, the load sees only older entries.
- Order is strict FIFO; two stores to the same address drain oldest first.

## Timing
- Reset (reset=0, asynchronous): head=tail=0, count=0, empty=1, st_ready=1, dm_we=0, ld_conflict=0 (when ld_valid=0), dm_addr=ld_addr. Entry contents are cleared to 0. Stores pending mid-drain are discarded and no partial write is issued.
- Push-to-drain latency is at least 1 cycle: an entry pushed at edge N can drive dm_we in cycle N+1.
- With ld_valid=0 continuously, DEPTH entries drain in DEPTH consecutive cycles, one per cycle.
- st_ready, ld_conflict, dm_* and empty are combinational from registered state and current inputs. count is registered.
- A conflicting load observes ld_conflict=0 in the cycle after its last matching entry pops.
- The memory samples dm_we/dm_addr/dm_wd at the same rising edge that pops the head.

## Test plan
- Reset: hold reset=0 and no clock edge → empty=1, count=0, st_ready=1, dm_we=0. Outputs change with no clock edge.
- Single store: push addr 0x0000_0010, data 0x1234_5678, ld_valid=0 → next cycle dm_we=1, dm_addr=0x10, dm_wd=0x12345678; cycle after that empty=1.
- Fill under load pressure:
  - Hold ld_valid=1, ld_addr=0x100 (non-matching); push 4 stores to 0x0/0x4/0x8/0xC → count=4, st_ready=0, dm_we=0, dm_addr=0x100.
  - Then drop ld_valid → dm_addr sequence 0x0,0x4,0x8,0xC over 4 cycles, then empty=1.
- Conflict:
  - Queue holds {0x20, 0xAAAA_AAAA}; assert ld_valid, ld_addr=0x22 → ld_conflict=1, dm_we=1, dm_addr=0x20.
  - Next cycle → ld_conflict=0, dm_we=0, dm_addr=0x22.
- Simultaneous push/pop: count=2, ld_valid=0, push 0x40 → count stays 2; drain order stays oldest-first, with 0x40 last.
- Wrap-around: push and drain 10 stores in continuous streaming → pointers wrap past DEPTH-1, all 10 addresses/data appear on dm_* in order, and no entry is lost or duplicated.
